// File: rtl/screen_sel_pkg.sv
// Shared types and constants for the screen selector: FSM states, menu row codes
// and the colour palette lookup driven to every renderer.
package screen_sel_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    PEND = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [3:0] ROW_START   = 4'd0;
  localparam logic [3:0] ROW_LEVEL   = 4'd1;
  localparam logic [3:0] ROW_PALETTE = 4'd2;

  // Returns {background, foreground}; out-of-range indices fall back to entry 0.
  function automatic logic [23:0] palette_lut(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = {12'h333, 12'hfff};
      3'd1:    c = {12'h099, 12'hf66};
      3'd2:    c = {12'h909, 12'h6f6};
      3'd3:    c = {12'h990, 12'h66f};
      3'd4:    c = {12'h339, 12'hff6};
      3'd5:    c = {12'h933, 12'h6ff};
      3'd6:    c = {12'h393, 12'hf6f};
      default: c = {12'h333, 12'hfff};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/menu_hit_decoder.sv
// Combinational menu hit test: maps a mouse position to the button row it lies in.
// Rows share one column and repeat every BTN_PITCH lines.
module menu_hit_decoder #(
  parameter int POS_W     = 12,
  parameter int BTN_X0    = 362,
  parameter int BTN_X1    = 674,
  parameter int BTN_Y0    = 46,
  parameter int BTN_H     = 100,
  parameter int BTN_PITCH = 192,
  parameter int N_ROWS    = 4
) (
  input  logic [POS_W-1:0] x_i,
  input  logic [POS_W-1:0] y_i,
  output logic             hit_o,
  output logic [3:0]       row_o
);

  logic [31:0] x_w;
  logic [31:0] y_w;
  logic        col_ok;

  assign x_w    = 32'(x_i);
  assign y_w    = 32'(y_i);
  assign col_ok = (x_w >= 32'(BTN_X0)) && (x_w <= 32'(BTN_X1));

  always_comb begin
    hit_o = 1'b0;
    row_o = 4'd0;
    for (int k = 0; k < N_ROWS; k++) begin
      if (col_ok && (y_w >= 32'(BTN_Y0 + k * BTN_PITCH)) &&
          (y_w <= 32'(BTN_Y0 + k * BTN_PITCH + BTN_H))) begin
        hit_o = 1'b1;
        row_o = 4'(k);
      end
    end
  end

endmodule

// File: rtl/screen_sel_ctl.sv
// Top-level screen selector: decodes menu clicks, switches renderers on the vblank
// rising edge and registers the chosen renderer's pixel and syncs onto the VGA pins.
module screen_sel_ctl
  import screen_sel_pkg::*;
#(
  parameter int N_SCREENS  = 3,
  parameter int N_LEVELS   = 2,
  parameter int N_PALETTES = 7,
  parameter int RGB_W      = 12,
  parameter int POS_W      = 12,
  parameter int BTN_X0     = 362,
  parameter int BTN_X1     = 674,
  parameter int BTN_Y0     = 46,
  parameter int BTN_H      = 100,
  parameter int BTN_PITCH  = 192
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         vblnk_in,
  input  logic [POS_W-1:0]             xpos,
  input  logic [POS_W-1:0]             ypos,
  input  logic                         mouse_left,
  input  logic                         button,
  input  logic [N_SCREENS*RGB_W-1:0]   rgb_src,
  input  logic [N_SCREENS-1:0]         hsync_src,
  input  logic [N_SCREENS-1:0]         vsync_src,
  output logic [RGB_W-1:0]             rgb_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic [2:0]                   screen_out,
  output logic [2:0]                   level,
  output logic [2:0]                   palette_idx,
  output logic [RGB_W-1:0]             color1,
  output logic [RGB_W-1:0]             color2
);

  state_t state_q, state_d;
  logic [2:0] target_q, target_d;
  logic [2:0] screen_q, screen_d;
  logic [2:0] level_q, level_d;
  logic [2:0] palette_q, palette_d;
  logic mouse_left_q, button_q, vblnk_q;
  logic [RGB_W-1:0] rgb_q, color1_q, color2_q;
  logic hsync_q, vsync_q;

  logic click, back, frame;
  logic hit;
  logic [3:0] row;
  logic [RGB_W-1:0] rgb_sel;
  logic hsync_sel, vsync_sel;
  logic [23:0] lut;

  assign click = mouse_left & ~mouse_left_q;
  assign back  = button & ~button_q;
  assign frame = vblnk_in & ~vblnk_q;

  // Row N_SCREENS is the last selectable one; anything further down never hits.
  menu_hit_decoder #(
    .POS_W    (POS_W),
    .BTN_X0   (BTN_X0),
    .BTN_X1   (BTN_X1),
    .BTN_Y0   (BTN_Y0),
    .BTN_H    (BTN_H),
    .BTN_PITCH(BTN_PITCH),
    .N_ROWS   (N_SCREENS + 1)
  ) u_hit (
    .x_i  (xpos),
    .y_i  (ypos),
    .hit_o(hit),
    .row_o(row)
  );

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    screen_d  = screen_q;
    level_d   = level_q;
    palette_d = palette_q;
    case (state_q)
      MENU: begin
        if (click && hit) begin
          case (row)
            ROW_START: begin
              target_d = 3'd1;
              state_d  = PEND;
            end
            ROW_LEVEL:
              level_d = (level_q == 3'(N_LEVELS - 1)) ? 3'd0 : level_q + 3'd1;
            ROW_PALETTE:
              palette_d = (palette_q == 3'(N_PALETTES - 1)) ? 3'd0 : palette_q + 3'd1;
            default: begin
              target_d = 3'(row - 4'd1);
              state_d  = PEND;
            end
          endcase
        end
      end
      PEND: begin
        // The frame edge takes priority so a coincident back press cannot abort a due switch.
        if (frame) begin
          screen_d = target_q;
          state_d  = (target_q == 3'd0) ? MENU : RUN;
        end else if (back && (target_q != 3'd0)) begin
          state_d = MENU;
        end
      end
      RUN: begin
        if (back) begin
          target_d = 3'd0;
          state_d  = PEND;
        end
      end
      default: state_d = MENU;
    endcase
  end

  always_comb begin
    rgb_sel   = rgb_src[RGB_W-1:0];
    hsync_sel = hsync_src[0];
    vsync_sel = vsync_src[0];
    for (int k = 0; k < N_SCREENS; k++) begin
      if (screen_q == 3'(k)) begin
        rgb_sel   = rgb_src[k*RGB_W +: RGB_W];
        hsync_sel = hsync_src[k];
        vsync_sel = vsync_src[k];
      end
    end
  end

  assign lut = palette_lut(palette_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MENU;
      target_q     <= 3'd0;
      screen_q     <= 3'd0;
      level_q      <= 3'd0;
      palette_q    <= 3'd0;
      mouse_left_q <= 1'b0;
      button_q     <= 1'b0;
      vblnk_q      <= 1'b0;
      rgb_q        <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      color1_q     <= RGB_W'(12'h333);
      color2_q     <= RGB_W'(12'hfff);
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      screen_q     <= screen_d;
      level_q      <= level_d;
      palette_q    <= palette_d;
      mouse_left_q <= mouse_left;
      button_q     <= button;
      vblnk_q      <= vblnk_in;
      rgb_q        <= rgb_sel;
      hsync_q      <= hsync_sel;
      vsync_q      <= vsync_sel;
      color1_q     <= RGB_W'(lut[23:12]);
      color2_q     <= RGB_W'(lut[11:0]);
    end
  end

  assign rgb_out     = rgb_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign screen_out  = screen_q;
  assign level       = level_q;
  assign palette_idx = palette_q;
  assign color1      = color1_q;
  assign color2      = color2_q;

endmodule

// File: tb/tb_screen_sel_ctl.sv
// Directed bench for screen_sel_ctl: a 3-screen and a 4-screen instance share all
// control stimulus; a click table plus hand sequences for switching and back handling.
module tb_screen_sel_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblnk_in;
  logic [11:0] xpos, ypos;
  logic        mouse_left;
  logic        button;

  logic [35:0] rgb_src3;
  logic [2:0]  hs_src3, vs_src3;
  logic [47:0] rgb_src4;
  logic [3:0]  hs_src4, vs_src4;

  logic [11:0] rgb3, rgb4, c1_3, c2_3, c1_4, c2_4;
  logic        hs3, vs3, hs4, vs4;
  logic [2:0]  scr3, lvl3, pal3, scr4, lvl4, pal4;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] lvl;
    logic [2:0] pal;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  screen_sel_ctl #(.N_SCREENS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .vblnk_in(vblnk_in), .xpos(xpos), .ypos(ypos),
    .mouse_left(mouse_left), .button(button), .rgb_src(rgb_src3),
    .hsync_src(hs_src3), .vsync_src(vs_src3), .rgb_out(rgb3), .hsync_out(hs3),
    .vsync_out(vs3), .screen_out(scr3), .level(lvl3), .palette_idx(pal3),
    .color1(c1_3), .color2(c2_3)
  );

  screen_sel_ctl #(.N_SCREENS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .vblnk_in(vblnk_in), .xpos(xpos), .ypos(ypos),
    .mouse_left(mouse_left), .button(button), .rgb_src(rgb_src4),
    .hsync_src(hs_src4), .vsync_src(vs_src4), .rgb_out(rgb4), .hsync_out(hs4),
    .vsync_out(vs4), .screen_out(scr4), .level(lvl4), .palette_idx(pal4),
    .color1(c1_4), .color2(c2_4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic click_at(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
  endtask

  task automatic vblank();
    vblnk_in = 1'b1;
    tick();
    vblnk_in = 1'b0;
    tick();
  endtask

  task automatic back_pulse();
    button = 1'b1;
    tick();
    button = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rgb_src3 = {12'hC22, 12'hB11, 12'hA00};
    hs_src3  = 3'b010;
    vs_src3  = 3'b100;
    rgb_src4 = {12'hD33, 12'hC22, 12'hB11, 12'hA00};
    hs_src4  = 4'b0010;
    vs_src4  = 4'b0100;
    rst_n = 1'b0; vblnk_in = 1'b0; xpos = '0; ypos = '0;
    mouse_left = 1'b0; button = 1'b0;

    tbl[0]  = '{500, 300, 3'd1, 3'd0};
    tbl[1]  = '{500, 300, 3'd0, 3'd0};
    tbl[2]  = '{700, 300, 3'd0, 3'd0};
    tbl[3]  = '{500, 180, 3'd0, 3'd0};
    tbl[4]  = '{361, 480, 3'd0, 3'd0};
    tbl[5]  = '{362, 480, 3'd0, 3'd1};
    tbl[6]  = '{674, 430, 3'd0, 3'd2};
    tbl[7]  = '{674, 530, 3'd0, 3'd3};
    tbl[8]  = '{500, 531, 3'd0, 3'd3};
    tbl[9]  = '{500, 429, 3'd0, 3'd3};
    tbl[10] = '{675, 480, 3'd0, 3'd3};
    tbl[11] = '{500, 338, 3'd1, 3'd3};
    tbl[12] = '{500, 237, 3'd1, 3'd3};

    // 1: reset values
    tick(3);
    chk("rst_rgb", rgb3, 12'h000);
    chk("rst_screen", scr3, 3'd0);
    chk("rst_level", lvl3, 3'd0);
    chk("rst_palette", pal3, 3'd0);
    chk("rst_color1", c1_3, 12'h333);
    chk("rst_color2", c2_3, 12'hfff);
    rst_n = 1'b1;
    tick();
    chk("rel_rgb_src0", rgb3, 12'hA00);

    // mid-operation reset is asynchronous
    click_at(500, 480);
    click_at(500, 300);
    chk("pre_rst_pal", pal3, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pal", pal3, 3'd0);
    chk("async_rst_lvl", lvl3, 3'd0);
    chk("async_rst_rgb", rgb3, 12'h000);
    chk("async_rst_c1", c1_3, 12'h333);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel2_rgb_src0", rgb3, 12'hA00);

    // 4 + boundaries: click table in MENU
    for (int i = 0; i < 13; i++) begin
      click_at(tbl[i].x, tbl[i].y);
      chk($sformatf("tbl%0d_level", i), lvl3, tbl[i].lvl);
      chk($sformatf("tbl%0d_palette", i), pal3, tbl[i].pal);
      chk($sformatf("tbl%0d_level4", i), lvl4, tbl[i].lvl);
    end
    chk("tbl_screen", scr3, 3'd0);

    // click and back in the same MENU cycle: click processed
    xpos = 12'd500; ypos = 12'd300;
    mouse_left = 1'b1; button = 1'b1;
    tick();
    mouse_left = 1'b0; button = 1'b0;
    tick();
    chk("click_back_level", lvl3, 3'd0);

    // 3: held button is one click; palette wrap and colour latency
    do_reset();
    xpos = 12'd500; ypos = 12'd480;
    mouse_left = 1'b1;
    tick();
    chk("hold_pal_1cyc", pal3, 3'd1);
    chk("hold_c1_lag", c1_3, 12'h333);
    tick();
    chk("hold_c1", c1_3, 12'h099);
    chk("hold_c2", c2_3, 12'hf66);
    tick(998);
    chk("hold_pal_once", pal3, 3'd1);
    mouse_left = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) click_at(500, 480);
    chk("pal_6", pal3, 3'd6);
    chk("pal_6_c1", c1_3, 12'h393);
    click_at(500, 480);
    chk("pal_wrap", pal3, 3'd0);
    chk("pal_wrap_c1", c1_3, 12'h333);

    // 2: start click, switch only at vblank rise
    click_at(500, 90);
    tick(5);
    chk("pend_screen", scr3, 3'd0);
    chk("pend_rgb_old", rgb3, 12'hA00);
    vblnk_in = 1'b1;
    tick();
    chk("sw_screen", scr3, 3'd1);
    chk("sw_rgb_lag", rgb3, 12'hA00);
    tick();
    chk("sw_rgb", rgb3, 12'hB11);
    chk("sw_hsync", hs3, 1'b1);
    chk("sw_vsync", vs3, 1'b0);
    tick(3);
    vblnk_in = 1'b0;
    tick();
    chk("vblank_level_no_reswitch", scr3, 3'd1);

    // RUN ignores clicks
    click_at(500, 300);
    chk("run_click_ignored", lvl3, 3'd0);

    // 5: back from RUN -> PEND -> MENU at vblank
    back_pulse();
    chk("back_pend_screen", scr3, 3'd1);
    vblank();
    chk("back_menu_screen", scr3, 3'd0);
    chk("back_menu_rgb", rgb3, 12'hA00);
    click_at(500, 300);
    chk("menu_again_level", lvl3, 3'd1);

    // frame and back together in PEND: switch taken
    click_at(500, 90);
    button = 1'b1; vblnk_in = 1'b1;
    tick();
    button = 1'b0; vblnk_in = 1'b0;
    tick();
    chk("frame_wins_screen", scr3, 3'd1);
    chk("frame_wins_rgb", rgb3, 12'hB11);

    // 6: four-screen instance
    do_reset();
    click_at(500, 650);
    vblank();
    chk("row3_scr4", scr4, 3'd2);
    chk("row3_rgb4", rgb4, 12'hC22);
    chk("row3_scr3", scr3, 3'd2);
    back_pulse();
    vblank();
    chk("row3_back4", scr4, 3'd0);
    click_at(500, 850);
    vblank();
    chk("row4_scr4", scr4, 3'd3);
    chk("row4_rgb4", rgb4, 12'hD33);
    chk("row4_ignored3", scr3, 3'd0);
    back_pulse();
    vblank();
    chk("row4_back4", scr4, 3'd0);
    click_at(500, 1050);
    vblank();
    chk("row5_ignored4", scr4, 3'd0);
    click_at(500, 850);
    back_pulse();
    vblank();
    chk("cancel_scr4", scr4, 3'd0);
    chk("cancel_rgb4", rgb4, 12'hA00);
    click_at(500, 300);
    chk("cancel_menu_level4", lvl4, 3'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
